// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding (matches RISC-V funct3) and controller state encoding.
package muldiv_unit_pkg;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int MD_OP_WIDTH      = 3;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit. One shift-add or
// restoring-division step per cycle on magnitudes; signs are restored
// when the last step is registered. Divide-by-zero and signed overflow
// are resolved at acceptance and skip the iteration entirely.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = RISCV_WORD_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [MD_OP_WIDTH-1:0] op_i,
    input  logic [WIDTH-1:0]       operand_a_i,
    input  logic [WIDTH-1:0]       operand_b_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH-1:0]       result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;       // product high half / partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0]   mcand_q, mcand_d; // |a| for multiply, |b| for divide
    logic               neg_q, neg_d;     // final result must be negated
    logic [WIDTH-1:0]   result_q, result_d;

    md_op_e             op_in;
    logic               is_div_in, signed_a, signed_b, a_neg, b_neg;
    logic               b_zero, sign_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH+1:0]   add_base, add_oper, add_sum;
    logic [WIDTH-1:0]   hi_step, lo_step, div_val;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   final_res;

    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign result_o = result_q;

    // Decode the incoming request: signedness, operand magnitudes, special cases
    always_comb begin
        op_in     = md_op_e'(op_i);
        is_div_in = op_i[2];
        signed_a  = is_div_in ? ~op_i[0] : (op_in == MD_MULH || op_in == MD_MULHSU);
        signed_b  = is_div_in ? ~op_i[0] : (op_in == MD_MULH);
        a_neg     = signed_a & operand_a_i[WIDTH-1];
        b_neg     = signed_b & operand_b_i[WIDTH-1];
        a_mag     = a_neg ? -operand_a_i : operand_a_i;
        b_mag     = b_neg ? -operand_b_i : operand_b_i;
        b_zero    = (operand_b_i == '0);
        sign_ovf  = ~op_i[0] && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                    && (operand_b_i == '1);
    end

    // Shared adder: shift-add for multiply, trial subtract for restoring divide
    always_comb begin
        if (op_q[2]) begin
            add_base = {1'b0, hi_q, lo_q[WIDTH-1]};
            add_oper = ~{2'b00, mcand_q};
        end else begin
            add_base = {2'b00, hi_q};
            add_oper = lo_q[0] ? {2'b00, mcand_q} : '0;
        end
        add_sum = add_base + add_oper + {{(WIDTH+1){1'b0}}, op_q[2]};

        if (op_q[2]) begin
            hi_step = add_sum[WIDTH+1] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : add_sum[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], ~add_sum[WIDTH+1]};
        end else begin
            hi_step = add_sum[WIDTH:1];
            lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Final sign restoration and result selection for the last step
    always_comb begin
        prod     = {hi_step, lo_step};
        prod_fix = neg_q ? -prod : prod;
        div_val  = op_q[1] ? hi_step : lo_step;
        if (op_q[2]) begin
            final_res = neg_q ? -div_val : div_val;
        end else if (op_q == MD_MUL) begin
            final_res = prod_fix[WIDTH-1:0];
        end else begin
            final_res = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic for the controller and datapath registers
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        result_d = result_q;
        unique case (state_q)
            MD_IDLE: begin
                if (valid_i) begin
                    op_d  = op_in;
                    cnt_d = CNT_W'(WIDTH - 1);
                    hi_d  = '0;
                    neg_d = is_div_in && op_i[1] ? a_neg : (a_neg ^ b_neg);
                    if (is_div_in && b_zero) begin
                        result_d = op_i[1] ? operand_a_i : '1;
                        state_d  = MD_DONE;
                    end else if (is_div_in && sign_ovf) begin
                        result_d = op_i[1] ? '0 : operand_a_i;
                        state_d  = MD_DONE;
                    end else begin
                        mcand_d = is_div_in ? b_mag : a_mag;
                        lo_d    = is_div_in ? a_mag : b_mag;
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d    = '0;
                    result_d = final_res;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: begin
                if (ready_i) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush_i) state_d = MD_IDLE;
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, measure cycles to valid_o (cycle 1 = first cycle after accept), consume result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk_i);
        op_i = op; operand_a_i = a; operand_b_i = b; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1 valid_i = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq(tag, result_o, exp_res);
        @(posedge clk_i); #1 ready_i = 1'b0;
    endtask

    initial begin
        int vcount;
        #12;
        check_eq("reset ready_o", {31'd0, ready_o}, 32'd1);
        check_eq("reset valid_o", {31'd0, valid_o}, 32'd0);
        check_eq("reset result_o", result_o, 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;

        run_op("MUL 7*-3",        MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("MULH min*min",    MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("MULHSU -1*max",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("MULHU max*max",   MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("DIV -7/2",        MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("REM -7/2",        MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("DIVU 7/2",        MD_DIVU,   32'd7,        32'd2,        32'd3,        33);
        run_op("REMU 7/2",        MD_REMU,   32'd7,        32'd2,        32'd1,        33);
        run_op("DIV 5/0",         MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("REMU 5/0",        MD_REMU,   32'd5,        32'd0,        32'd5,        1);
        run_op("DIV ovf",         MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM ovf",         MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Backpressure: result held, request ignored while DONE
        @(negedge clk_i);
        op_i = MD_MUL; operand_a_i = 32'd6; operand_b_i = 32'd7; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1 valid_i = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk_i);
            if (valid_o) break;
        end
        check_eq("bp valid_o", {31'd0, valid_o}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            op_i = MD_DIVU; operand_a_i = 32'd100; operand_b_i = 32'd5; valid_i = 1'b1;
            @(negedge clk_i);
            check_eq("bp result hold", result_o, 32'd42);
            check_eq("bp ready_o low", {31'd0, ready_o}, 32'd0);
            check_eq("bp valid_o hold", {31'd0, valid_o}, 32'd1);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk_i); #1 ready_i = 1'b0;
        @(negedge clk_i);
        check_eq("bp ready_o after", {31'd0, ready_o}, 32'd1);
        check_eq("bp valid_o after", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        check_eq("bp no ghost op", {31'd0, ready_o}, 32'd1);

        // Flush at cycle 10 of a DIV
        op_i = MD_DIV; operand_a_i = 32'd100; operand_b_i = 32'd7; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1 valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check_eq("flush busy", {31'd0, ready_o}, 32'd0);
        flush_i = 1'b1;
        @(posedge clk_i); #1 flush_i = 1'b0;
        @(negedge clk_i);
        check_eq("flush ready_o", {31'd0, ready_o}, 32'd1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) vcount++;
        end
        check_eq("flush no valid", vcount, 0);
        run_op("MUL 3*4 after flush", MD_MUL, 32'd3, 32'd4, 32'd12, 33);

        // Flush coincident with acceptance drops the request
        @(negedge clk_i);
        op_i = MD_MUL; operand_a_i = 32'd9; operand_b_i = 32'd9; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1 valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check_eq("flush drops req", {31'd0, ready_o}, 32'd1);

        // Asynchronous reset mid-CALC
        op_i = MD_MULHU; operand_a_i = 32'hFFFFFFFF; operand_b_i = 32'd3; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1 valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check_eq("rst pre busy", {31'd0, ready_o}, 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("async rst valid_o", {31'd0, valid_o}, 32'd0);
        check_eq("async rst ready_o", {31'd0, ready_o}, 32'd1);
        check_eq("async rst result_o", result_o, 32'd0);
        @(negedge clk_i); rst_ni = 1'b1;
        run_op("REMU 7/2 after rst", MD_REMU, 32'd7, 32'd2, 32'd1, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
